// File: rtl/bp_pkg.sv
// Shared types and helpers for the set-associative branch predictor.
// Widths are passed in as arguments so that one package serves every
// parameterisation of the predictor.
package bp_pkg;

    localparam int MAX_ADDR = 64;
    localparam int MAX_CTR  = 4;

    // Generic BTB entry, sized for the widest supported configuration.
    typedef struct packed {
        logic                valid;
        logic [MAX_ADDR-1:0] tag;
        logic [MAX_ADDR-1:0] target;
        logic [MAX_CTR-1:0]  ctr;
    } bp_entry_t;

    // Weakly-not-taken: all ones except the MSB.
    function automatic logic [MAX_CTR-1:0] CTR_WNT(input int ctr_bits);
        return MAX_CTR'((1 << (ctr_bits - 1)) - 1);
    endfunction

    // Weakly-taken: MSB set, rest clear.
    function automatic logic [MAX_CTR-1:0] CTR_WT(input int ctr_bits);
        return MAX_CTR'(1 << (ctr_bits - 1));
    endfunction

    // Saturating up/down step of a ctr_bits-wide direction counter.
    function automatic logic [MAX_CTR-1:0] sat_update(input logic [MAX_CTR-1:0] ctr,
                                                      input logic               taken,
                                                      input int                 ctr_bits);
        logic [MAX_CTR-1:0] top;
        top = MAX_CTR'((1 << ctr_bits) - 1);
        if (taken)
            return (ctr == top) ? ctr : ctr + 1'b1;
        else
            return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

    // Set index: word-aligned address bits just above the byte offset.
    function automatic logic [MAX_ADDR-1:0] idx_of(input logic [MAX_ADDR-1:0] addr,
                                                   input int                  idx_bits);
        return (addr >> 2) & ((64'd1 << idx_bits) - 64'd1);
    endfunction

    // Tag: everything above the set index.
    function automatic logic [MAX_ADDR-1:0] tag_of(input logic [MAX_ADDR-1:0] addr,
                                                   input int                  idx_bits);
        return addr >> (idx_bits + 2);
    endfunction

endpackage

// File: rtl/bp_victim_sel.sv
// Replacement victim selection for one BTB set: the lowest invalid way,
// otherwise the round-robin pointer, which then advances.
module bp_victim_sel #(
    parameter int WAYS = 2,
    parameter int RRW  = 1
) (
    input  logic [WAYS-1:0] valid,
    input  logic [RRW-1:0]  rr_ptr,
    output logic [RRW-1:0]  victim,
    output logic [RRW-1:0]  rr_next
);

    logic found;

    // Priority-pick the first free way; fall back to round-robin on a full set.
    always_comb begin
        found   = 1'b0;
        victim  = rr_ptr;
        rr_next = rr_ptr;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[w] && !found) begin
                found  = 1'b1;
                victim = RRW'(w);
            end
        end
        if (!found)
            rr_next = (WAYS == 1) ? '0 : rr_ptr + 1'b1;
    end

endmodule

// File: rtl/branch_predict_sa.sv
// Set-associative BTB with saturating direction counters, per-set
// round-robin replacement and optional gshare direction lookup.
// Lookup is split over two cycles: next_pc selects and registers a set,
// pc is tag-compared against it the following cycle. Tag and target
// storage are plain flop arrays with a registered read, so they can be
// swapped for 1-cycle SRAM macros without changing the pipeline.
module branch_predict_sa
    import bp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 8,
    parameter int USE_GSHARE = 0
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic [ADDR_WIDTH-1:0] next_pc,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  predict_hit,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_target_pc,
    input  logic                  branch_ex,
    input  logic [ADDR_WIDTH-1:0] branch_pc_ex,
    input  logic [ADDR_WIDTH-1:0] branch_target_pc,
    input  logic                  branch_taken_ex,
    input  logic                  flush_bp
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX - 2;
    localparam int RRW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(CTR_WNT(CTR_BITS));
    localparam logic [CTR_BITS-1:0] WT  = CTR_BITS'(CTR_WT(CTR_BITS));

    function automatic logic [CTR_BITS-1:0] bump(input logic [CTR_BITS-1:0] c, input logic t);
        return CTR_BITS'(sat_update(MAX_CTR'(c), t, CTR_BITS));
    endfunction

    // Storage
    logic [WAYS-1:0]       valid_mem [SETS];
    logic [TAG_W-1:0]      tag_mem   [SETS][WAYS];
    logic [ADDR_WIDTH-1:0] tgt_mem   [SETS][WAYS];
    logic [CTR_BITS-1:0]   ctr_mem   [SETS][WAYS];
    logic [CTR_BITS-1:0]   pht       [SETS];
    logic [RRW-1:0]        rr_mem    [SETS];
    logic [GHR_BITS-1:0]   ghr;

    // Registered lookup set
    logic [WAYS-1:0]       rd_valid;
    logic [TAG_W-1:0]      rd_tag [WAYS];
    logic [ADDR_WIDTH-1:0] rd_tgt [WAYS];
    logic [CTR_BITS-1:0]   rd_ctr [WAYS];
    logic [CTR_BITS-1:0]   rd_pht;

    // Address decode
    logic [IDX-1:0]   lk_idx, lk_pht_idx, up_idx, up_pht_idx;
    logic [TAG_W-1:0] fe_tag, up_tag;

    assign lk_idx     = IDX'(idx_of(64'(next_pc), IDX));
    assign up_idx     = IDX'(idx_of(64'(branch_pc_ex), IDX));
    assign fe_tag     = TAG_W'(tag_of(64'(pc), IDX));
    assign up_tag     = TAG_W'(tag_of(64'(branch_pc_ex), IDX));
    assign lk_pht_idx = lk_idx ^ IDX'(ghr);
    assign up_pht_idx = up_idx ^ IDX'(ghr);

    // Update path
    logic                up_hit;
    logic [RRW-1:0]      up_way, vic_way, rr_next, wr_way;
    logic [CTR_BITS-1:0] new_ctr;
    logic                up_en;

    // Tag match of the resolving branch against its set, lowest way first.
    always_comb begin
        up_hit = 1'b0;
        up_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[up_idx][w] && (tag_mem[up_idx][w] == up_tag) && !up_hit) begin
                up_hit = 1'b1;
                up_way = RRW'(w);
            end
        end
    end

    bp_victim_sel #(
        .WAYS (WAYS),
        .RRW  (RRW)
    ) u_victim_sel (
        .valid   (valid_mem[up_idx]),
        .rr_ptr  (rr_mem[up_idx]),
        .victim  (vic_way),
        .rr_next (rr_next)
    );

    assign up_en   = branch_ex && !flush_bp;
    assign wr_way  = up_hit ? up_way : vic_way;
    assign new_ctr = up_hit ? bump(ctr_mem[up_idx][up_way], branch_taken_ex)
                            : (branch_taken_ex ? WT : WNT);

    // Valid bits, counters, round-robin pointers, PHT and GHR; flush beats update.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                rr_mem[s]    <= '0;
                pht[s]       <= WNT;
                for (int w = 0; w < WAYS; w++)
                    ctr_mem[s][w] <= WNT;
            end
            ghr <= '0;
        end else if (flush_bp) begin
            for (int s = 0; s < SETS; s++)
                valid_mem[s] <= '0;
            ghr <= '0;
        end else if (branch_ex) begin
            ctr_mem[up_idx][wr_way] <= new_ctr;
            if (!up_hit) begin
                valid_mem[up_idx][vic_way] <= 1'b1;
                rr_mem[up_idx]             <= rr_next;
            end
            if (USE_GSHARE != 0) begin
                pht[up_pht_idx] <= bump(pht[up_pht_idx], branch_taken_ex);
                ghr             <= GHR_BITS'({ghr, branch_taken_ex});
            end
        end
    end

    // Tag and target arrays carry no reset; the valid bits guard them.
    always_ff @(posedge cpu_clk) begin
        if (up_en) begin
            tgt_mem[up_idx][wr_way] <= branch_target_pc;
            if (!up_hit)
                tag_mem[up_idx][vic_way] <= up_tag;
        end
    end

    // Capture the set addressed by next_pc (pre-update contents, no bypass).
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            rd_valid <= '0;
            rd_pht   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                rd_tag[w] <= '0;
                rd_tgt[w] <= '0;
                rd_ctr[w] <= '0;
            end
        end else begin
            rd_valid <= valid_mem[lk_idx];
            rd_pht   <= pht[lk_pht_idx];
            for (int w = 0; w < WAYS; w++) begin
                rd_tag[w] <= tag_mem[lk_idx][w];
                rd_tgt[w] <= tgt_mem[lk_idx][w];
                rd_ctr[w] <= ctr_mem[lk_idx][w];
            end
        end
    end

    // Tag compare against pc and output select; lowest hitting way wins.
    logic [WAYS-1:0] way_hit;
    logic [RRW-1:0]  hit_way;

    always_comb begin
        way_hit           = '0;
        hit_way           = '0;
        predict_hit       = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = rd_valid[w] && (rd_tag[w] == fe_tag);
            if (way_hit[w] && !predict_hit) begin
                predict_hit = 1'b1;
                hit_way     = RRW'(w);
            end
        end
        predict_taken     = predict_hit &&
                            ((USE_GSHARE != 0) ? rd_pht[CTR_BITS-1] : rd_ctr[hit_way][CTR_BITS-1]);
        predict_target_pc = predict_hit ? rd_tgt[hit_way] : '0;
    end

    // Allocation only happens on a miss, so two ways can never share a tag.
    multi_hit_a: assert property (@(posedge cpu_clk) disable iff (cpu_rst) $onehot0(way_hit));

endmodule

// File: tb/tb_branch_predict_sa.sv
// Bench for branch_predict_sa: a local-counter and a gshare instance share
// the same stimulus; a behavioural BTB model produces expected lookups.
module tb_branch_predict_sa;
    import bp_pkg::*;

    localparam int AW   = 32;
    localparam int SETS = 64;
    localparam int WAYS = 2;
    localparam int CB   = 2;
    localparam int GB   = 4;
    localparam int CMAX = (1 << CB) - 1;
    localparam int HALF = 1 << (CB - 1);

    logic          cpu_clk = 1'b0;
    logic          cpu_rst;
    logic [AW-1:0] next_pc, pc, branch_pc_ex, branch_target_pc;
    logic          branch_ex, branch_taken_ex, flush_bp;
    logic          hit_l, taken_l, hit_g, taken_g;
    logic [AW-1:0] tgt_l, tgt_g;

    always #5 cpu_clk = ~cpu_clk;

    branch_predict_sa #(.ADDR_WIDTH(AW), .SETS(SETS), .WAYS(WAYS), .CTR_BITS(CB),
                        .GHR_BITS(GB), .USE_GSHARE(0)) u_dut_local (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .next_pc(next_pc), .pc(pc),
        .predict_hit(hit_l), .predict_taken(taken_l), .predict_target_pc(tgt_l),
        .branch_ex(branch_ex), .branch_pc_ex(branch_pc_ex), .branch_target_pc(branch_target_pc),
        .branch_taken_ex(branch_taken_ex), .flush_bp(flush_bp));

    branch_predict_sa #(.ADDR_WIDTH(AW), .SETS(SETS), .WAYS(WAYS), .CTR_BITS(CB),
                        .GHR_BITS(GB), .USE_GSHARE(1)) u_dut_gs (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .next_pc(next_pc), .pc(pc),
        .predict_hit(hit_g), .predict_taken(taken_g), .predict_target_pc(tgt_g),
        .branch_ex(branch_ex), .branch_pc_ex(branch_pc_ex), .branch_target_pc(branch_target_pc),
        .branch_taken_ex(branch_taken_ex), .flush_bp(flush_bp));

    // Reference model
    bp_entry_t m_btb [SETS][WAYS];
    int        m_rr  [SETS];
    int        m_pht [SETS];
    int        m_ghr;

    typedef struct {
        logic          hit;
        logic          tk_l;
        logic          tk_g;
        logic [AW-1:0] tgt;
        logic [AW-1:0] pc;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad   = 0;
    logic          mon_due = 1'b0;
    logic          lk_prev = 1'b0;
    logic [AW-1:0] last_npc = '0;
    logic [AW-1:0] cur_pc;

    function automatic int m_set(input logic [AW-1:0] a);
        return int'((a / 4) % SETS);
    endfunction

    function automatic logic [63:0] m_tag(input logic [AW-1:0] a);
        return 64'(a / (4 * SETS));
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s]  = 0;
            m_pht[s] = HALF - 1;
            for (int w = 0; w < WAYS; w++)
                m_btb[s][w] = '{valid: 1'b0, tag: '0, target: '0, ctr: 4'(HALF - 1)};
        end
        m_ghr = 0;
    endtask

    function automatic exp_t model_lookup(input logic [AW-1:0] a);
        exp_t e;
        int   s = m_set(a);
        e.hit = 1'b0; e.tk_l = 1'b0; e.tk_g = 1'b0; e.tgt = '0; e.pc = a;
        for (int w = 0; w < WAYS; w++) begin
            if (!e.hit && m_btb[s][w].valid && m_btb[s][w].tag == m_tag(a)) begin
                e.hit  = 1'b1;
                e.tgt  = AW'(m_btb[s][w].target);
                e.tk_l = (int'(m_btb[s][w].ctr) >= HALF);
                e.tk_g = (m_pht[s ^ m_ghr] >= HALF);
            end
        end
        return e;
    endfunction

    task automatic model_update(input logic [AW-1:0] a, input logic [AW-1:0] t, input logic tk);
        int s = m_set(a);
        int hw = -1;
        int v = -1;
        int c;
        int p;
        for (int w = 0; w < WAYS; w++)
            if (hw < 0 && m_btb[s][w].valid && m_btb[s][w].tag == m_tag(a)) hw = w;
        if (hw >= 0) begin
            c = int'(m_btb[s][hw].ctr);
            c = tk ? ((c < CMAX) ? c + 1 : c) : ((c > 0) ? c - 1 : c);
            m_btb[s][hw].ctr    = 4'(c);
            m_btb[s][hw].target = 64'(t);
        end else begin
            for (int w = 0; w < WAYS; w++)
                if (v < 0 && !m_btb[s][w].valid) v = w;
            if (v < 0) begin
                v       = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m_btb[s][v] = '{valid: 1'b1, tag: m_tag(a), target: 64'(t),
                            ctr: 4'(tk ? HALF : HALF - 1)};
        end
        p = s ^ m_ghr;
        m_pht[p] = tk ? ((m_pht[p] < CMAX) ? m_pht[p] + 1 : m_pht[p])
                      : ((m_pht[p] > 0) ? m_pht[p] - 1 : m_pht[p]);
        m_ghr = ((m_ghr * 2) + int'(tk)) % (1 << GB);
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                m_btb[s][w].valid = 1'b0;
        m_ghr = 0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s pc=%h actual=%h required=%h t=%0t", nm, cur_pc, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic step(input logic lk, input logic [AW-1:0] npc,
                        input logic up, input logic [AW-1:0] bpc, input logic [AW-1:0] btgt,
                        input logic btk, input logic fl);
        pc               = last_npc;
        mon_due          = lk_prev;
        next_pc          = npc;
        branch_ex        = up;
        branch_pc_ex     = bpc;
        branch_target_pc = btgt;
        branch_taken_ex  = btk;
        flush_bp         = fl;
        if (lk) exp_q.push_back(model_lookup(npc));
        if (fl) model_flush();
        else if (up) model_update(bpc, btgt, btk);
        last_npc = npc;
        lk_prev  = lk;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic lookup(input logic [AW-1:0] a);
        step(1'b1, a, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [AW-1:0] a, input logic [AW-1:0] t, input logic tk);
        step(1'b0, '0, 1'b1, a, t, tk, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hit_l"}, 64'(hit_l), 64'd0);
        chk({tag, "_tk_l"},  64'(taken_l), 64'd0);
        chk({tag, "_tgt_l"}, 64'(tgt_l), 64'd0);
        chk({tag, "_hit_g"}, 64'(hit_g), 64'd0);
        chk({tag, "_tk_g"},  64'(taken_g), 64'd0);
        chk({tag, "_tgt_g"}, 64'(tgt_g), 64'd0);
    endtask

    // Monitor: outputs for the previously captured lookup are valid now.
    always @(negedge cpu_clk) begin
        if (!cpu_rst && mon_due) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                cur_pc = pc;
                chk("scoreboard_underflow", 64'd1, 64'd0);
            end else begin
                e      = exp_q.pop_front();
                cur_pc = e.pc;
                chk("pc_align", 64'(pc), 64'(e.pc));
                chk("hit_l", 64'(hit_l), 64'(e.hit));
                chk("tk_l",  64'(taken_l), 64'(e.tk_l));
                chk("tgt_l", 64'(tgt_l), 64'(e.tgt));
                chk("hit_g", 64'(hit_g), 64'(e.hit));
                chk("tk_g",  64'(taken_g), 64'(e.tk_g));
                chk("tgt_g", 64'(tgt_g), 64'(e.tgt));
            end
        end
    end

    initial begin
        logic [AW-1:0] a, b, t;
        cpu_rst = 1'b1;
        next_pc = '0; pc = '0; branch_ex = 1'b0; branch_pc_ex = '0;
        branch_target_pc = '0; branch_taken_ex = 1'b0; flush_bp = 1'b0;
        cur_pc = '0;
        model_reset();
        #12;
        chk_zero("reset");
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        @(posedge cpu_clk);
        #1;

        // Cold miss, then counter training on one branch
        lookup(32'h100);
        update(32'h100, 32'h200, 1'b1);
        lookup(32'h100);
        update(32'h100, 32'h200, 1'b0);
        lookup(32'h100);
        for (int i = 0; i < 3; i++) update(32'h100, 32'h200, 1'b0);
        lookup(32'h100);

        // Fill a set and force a round-robin eviction
        update(32'h200, 32'h240, 1'b1);
        update(32'h300, 32'h340, 1'b1);
        lookup(32'h100);
        lookup(32'h200);
        lookup(32'h300);

        // Same-cycle allocate and lookup sees the old contents
        step(1'b1, 32'h400, 1'b1, 32'h400, 32'h480, 1'b1, 1'b0);
        lookup(32'h400);

        // Flush beats a simultaneous update
        step(1'b1, 32'h300, 1'b1, 32'h100, 32'h500, 1'b1, 1'b1);
        lookup(32'h100);
        lookup(32'h300);
        lookup(32'h400);
        update(32'h100, 32'h500, 1'b1);
        lookup(32'h100);

        // Reset with a hitting lookup in flight
        cpu_rst = 1'b1;
        pc      = last_npc;
        mon_due = 1'b0;
        lk_prev = 1'b0;
        #1;
        chk_zero("midrst");
        exp_q.delete();
        model_reset();
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        @(posedge cpu_clk);
        #1;
        lookup(32'h100);

        // Alternating pattern for gshare learning
        for (int i = 0; i < 16; i++) begin
            lookup(32'h100);
            update(32'h100, 32'h200, (i % 2) == 0);
        end

        // Randomised traffic over a few conflicting sets
        for (int i = 0; i < 400; i++) begin
            a = AW'(($urandom_range(0, 4) << 8) | ($urandom_range(0, 3) << 2));
            b = AW'(($urandom_range(0, 4) << 8) | ($urandom_range(0, 3) << 2));
            t = $urandom() & 32'hffff_fffc;
            step(($urandom() % 4) != 0, a, ($urandom() % 2) != 0, b, t,
                 ($urandom() % 2) != 0, ($urandom() % 40) == 0);
        end

        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        cur_pc = '0;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
